// File: rtl/led_blink_pkg.sv
// led_blink_pkg: shared mode type and channel-index width helper for led_blink_gen
package led_blink_pkg;
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_blink_gen_if.sv
// led_blink_gen_if: valid/ready configuration bus selecting one LED channel's mode and half-period
interface led_blink_gen_if
    import led_blink_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 25
);
    localparam int CH_W = ch_w(NUM_CH);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    mode_t            cfg_mode;
    logic [CNT_W-1:0] cfg_half;
    modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_half, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_mode, cfg_half, output cfg_ready);
endinterface

// File: rtl/led_blink_ch.sv
// led_blink_ch: one LED channel with mode, half-period counter, registered led and toggle strobe
module led_blink_ch
    import led_blink_pkg::*;
#(
    parameter int               CNT_W        = 25,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = '0,
    parameter mode_t            DEFAULT_MODE = MODE_BLINK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  mode_t            load_mode,
    input  logic [CNT_W-1:0] load_half,
    output logic             led,
    output logic             pulse
);
    mode_t            mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    assign tc = cnt == half;
    always_ff @(posedge clk) begin
        if (reset) begin
            mode  <= DEFAULT_MODE;
            half  <= DEFAULT_HALF;
            cnt   <= '0;
            led   <= DEFAULT_MODE != MODE_OFF;
            pulse <= 1'b0;
        end else if (load) begin
            mode  <= load_mode;
            half  <= load_half;
            cnt   <= '0;
            led   <= load_mode != MODE_OFF;
            pulse <= 1'b0;
        end else if (mode == MODE_BLINK || mode == MODE_ONESHOT) begin
            cnt   <= tc ? '0 : cnt + 1'b1;
            pulse <= tc;
            if (tc) begin
                led  <= mode == MODE_BLINK ? ~led : 1'b0;
                mode <= mode == MODE_BLINK ? MODE_BLINK : MODE_OFF;
            end
        end else begin
            cnt   <= '0;
            pulse <= 1'b0;
        end
    end
endmodule

// File: rtl/led_blink_gen.sv
// led_blink_gen: NUM_CH-channel LED blinker with one staged config write; LED_BLINK_ACTIVE_LOW_EN inverts led_out
module led_blink_gen
    import led_blink_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int CNT_W        = 25,
    parameter int DEFAULT_HALF = 12000000,
    parameter int DEFAULT_MODE = 2
) (
    input  logic              clk,
    input  logic              reset,
    led_blink_gen_if.slave    cfg,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] toggle_pulse
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam logic [1:0] DM = DEFAULT_MODE[1:0];
    logic             stg_valid;
    logic [CH_W-1:0]  stg_ch;
    mode_t            stg_mode;
    logic [CNT_W-1:0] stg_half;
    logic [NUM_CH-1:0] led;
    assign cfg.cfg_ready = !reset && !stg_valid;
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= 1'b0;
        end else begin
            stg_valid <= cfg.cfg_valid && cfg.cfg_ready;
            if (cfg.cfg_valid && cfg.cfg_ready) begin
                stg_ch   <= cfg.cfg_ch;
                stg_mode <= cfg.cfg_mode;
                stg_half <= cfg.cfg_half;
            end
        end
    end
    // out-of-range channel numbers match no instance, so the apply cycle is spent doing nothing
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_blink_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (CNT_W'(DEFAULT_HALF)),
            .DEFAULT_MODE (mode_t'(DM))
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .load      (stg_valid && stg_ch == CH_W'(i)),
            .load_mode (stg_mode),
            .load_half (stg_half),
            .led       (led[i]),
            .pulse     (toggle_pulse[i])
        );
    end
`ifdef LED_BLINK_ACTIVE_LOW_EN
    assign led_out = ~led;
`else
    assign led_out = led;
`endif
endmodule

// File: tb/tb_led_blink_gen.sv
// tb_led_blink_gen: directed stimulus against a per-channel elapsed-time model of led_blink_gen
module tb_led_blink_gen;
    import led_blink_pkg::*;
    localparam int NCH = 3;
`ifdef LED_BLINK_ACTIVE_LOW_EN
    localparam logic [NCH-1:0] INV = '1;
`else
    localparam logic [NCH-1:0] INV = '0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NCH-1:0] led_out, toggle_pulse;
    int checks = 0;
    int errors = 0;
    led_blink_gen_if #(.NUM_CH(NCH), .CNT_W(8)) bus ();
    led_blink_gen #(.NUM_CH(NCH), .CNT_W(8), .DEFAULT_HALF(4), .DEFAULT_MODE(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg          (bus.slave),
        .led_out      (led_out),
        .toggle_pulse (toggle_pulse)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask
    // model: each channel remembers its mode, half and the edge at which it was last (re)started
    int cyc = 0;
    int t0[NCH], mm[NCH], mh[NCH];
    bit live = 0, stg = 0;
    int sch, smode, shalf;
    always @(posedge clk) begin
        logic [NCH-1:0] el, ep;
        cyc++;
        if (reset) begin
            live = 1;
            stg = 0;
            for (int c = 0; c < NCH; c++) begin mm[c] = 2; mh[c] = 4; t0[c] = cyc; end
        end else if (stg) begin
            if (sch < NCH) begin mm[sch] = smode; mh[sch] = shalf; t0[sch] = cyc; end
            stg = 0;
        end else if (bus.cfg_valid) begin
            stg = 1;
            sch = int'(bus.cfg_ch);
            smode = int'(bus.cfg_mode);
            shalf = int'(bus.cfg_half);
        end
        #1;
        if (live) begin
            for (int c = 0; c < NCH; c++) begin
                int n, p;
                n = cyc - t0[c];
                p = mh[c] + 1;
                el[c] = mm[c] == 1 || (mm[c] == 2 && (n / p) % 2 == 0) || (mm[c] == 3 && n < p);
                ep[c] = (mm[c] == 2 && n > 0 && n % p == 0) || (mm[c] == 3 && n == p);
            end
            check("led_out", led_out, el ^ INV);
            check("toggle_pulse", toggle_pulse, ep);
            check("cfg_ready", NCH'(bus.cfg_ready), NCH'(!reset && !stg));
        end
    end
    task automatic do_reset;
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask
    // called just after a negedge; returns just after the negedge following the accept edge
    task automatic write(input int ch, input mode_t m, input int h);
        bit ok = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_ch = 2'(ch);
        bus.cfg_mode = m;
        bus.cfg_half = 8'(h);
        #1;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (bus.cfg_ready) ok = 1;
            else begin @(negedge clk); #1; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL write_accept ch=%0d: ready never rose within 8 cycles", ch); end
        @(posedge clk);
        @(negedge clk) bus.cfg_valid = 1'b0;
    endtask
    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch = '0;
        bus.cfg_mode = MODE_OFF;
        bus.cfg_half = '0;
        do_reset;
        #1 check("ready_after_reset", NCH'(bus.cfg_ready), 3'b001);
        repeat (5) @(posedge clk);
        #1 check("first_pulse", toggle_pulse, 3'b111);
        check("first_toggle_led", led_out, 3'b000 ^ INV);
        @(negedge clk);
        write(1, MODE_BLINK, 0);
        repeat (12) @(negedge clk);
        write(2, MODE_ONESHOT, 9);
        repeat (15) @(negedge clk);
        write(2, MODE_BLINK, 3);
        repeat (10) @(negedge clk);
        write(0, MODE_OFF, 0);
        repeat (5) @(negedge clk);
        write(0, MODE_ON, 7);
        repeat (50) @(negedge clk);
        do_reset;
        repeat (8) @(negedge clk);
        write(0, MODE_BLINK, 4);
        @(posedge clk);
        #1 check("apply_wins_pulse", toggle_pulse, 3'b110);
        check("apply_wins_led", led_out, 3'b111 ^ INV);
        @(negedge clk);
        write(3, MODE_OFF, 0);
        repeat (10) @(negedge clk);
        write(2, MODE_ONESHOT, 20);
        repeat (5) @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_ch = 2'd1;
        bus.cfg_mode = MODE_OFF;
        @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 check("reset_ready", NCH'(bus.cfg_ready), 3'b000);
        check("reset_led", led_out, 3'b111 ^ INV);
        check("reset_pulse", toggle_pulse, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
